serial_queue_bridge: RTL and testbench
======================================

# serial_queue_bridge

Parametrised serial-to-parallel bridge: assembles bits sampled on `data_in` into `WIDTH`-bit words and buffers them in a `DEPTH`-entry FIFO read through a show-ahead port. It is the next generation of the fixed 8-bit deserializer and queue pair in the top level. It adds:
- selectable bit order;
- a pending-word hold stage with backpressure status;
- explicit full, empty and overflow reporting.

## Interface
Parameters:
- `WIDTH`, 8, bits per assembled word (≥2)
- `DEPTH`, 8, FIFO entries (power of two, ≥2)
- `MSB_FIRST`, 1, 1: first received bit lands in bit `WIDTH-1`; 0: first bit lands in bit 0

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `write_in` in 1: `data_in` is valid this cycle
- `data_in` in 1: serial bit
- `dequeue_in` in 1: pop the head word
- `data_out` out `WIDTH`: head word (show-ahead); 0 when empty
- `len_out` out `$clog2(DEPTH+1)`: number of stored words
- `empty_out` out 1: `len_out == 0`
- `full_out` out 1: `len_out == DEPTH`
- `status_out` out 1: a complete word is held pending, waiting for FIFO space
- `overflow_out` out 1: one-cycle pulse when a `write_in` bit is dropped

## Operation
- **Reset (async):** clears the bit counter, shift register, pending register, FIFO pointers and length.
  - Outputs after reset: `data_out=0`, `len_out=0`, `empty_out=1`, `full_out=0`, `status_out=0`, `overflow_out=0`.
  - FIFO storage contents are don't-care.
- **Deserializer FSM:**
  - COLLECT:
    - Each `write_in` cycle shifts `data_in` in (MSB- or LSB-first per `MSB_FIRST`) and increments the bit counter, 0..`WIDTH-1`.
    - On the `WIDTH`-th bit the word is complete and the counter wraps to 0.
    - If the FIFO can accept (see push rule), the word is pushed on that same edge and the FSM stays in COLLECT.
    - Otherwise the word is latched into the pending register and the FSM goes to HOLD.
  - HOLD:
    - `status_out=1`.
    - `write_in` bits are dropped and `overflow_out` pulses for each dropped bit.
    - The pending word is pushed on the first edge where the push rule holds, then the FSM returns to COLLECT.
    - `write_in` in that same cycle is still dropped.
- **Push rule:** `len_out < DEPTH`, or `dequeue_in` asserted while non-empty (a simultaneous pop frees the slot).
- **Pop:**
  - `dequeue_in` with `empty_out=1` is ignored, with no error.
  - Otherwise the read pointer advances and `len_out` decrements, unless a push occurs in the same cycle, in which case `len_out` is unchanged.
- **Pointers:** wrap modulo `DEPTH`. `len_out` is the only full/empty source and saturates at 0 and `DEPTH` by construction.
- **Writes to full:** the FIFO is never written when full without a simultaneous pop, so no stored word is ever overwritten.

## Timing
- Last bit sampled at edge N: `len_out` increments and the word is stored at edge N.
  - If the FIFO was empty, `data_out` shows the word after edge N, i.e. zero added latency.
- Pop at edge N: `data_out` shows the next word, or 0 if empty, after edge N. `data_out` is combinational from the head entry and `empty_out`.
- HOLD entry: `status_out` rises after the completing edge.
- HOLD exit: `status_out` falls after the edge that pushes the pending word.
- `overflow_out` is registered: it is high for the cycle following the edge that dropped the bit.
- `full_out` and `empty_out` update on the same edge as `len_out`.
- Reset asserted mid-word or in HOLD: partial bits and the pending word are discarded immediately. The first bit after release is bit 0 of a new word.

## Test plan
- **Defaults, MSB-first:** `write_in` with bits 0,1,0,1,0,0,1,0 → after 8th edge `len_out=1`, `empty_out=0`, `data_out=0x52`. Then `dequeue_in` one cycle → `len_out=0`, `data_out=0`, `empty_out=1`.
- **`MSB_FIRST=0`:** bits 0,1,0,0,1,0,1,0 → `data_out=0x52`.
- **Fill to full:** write words 0x01..0x08 → `full_out=1`, `len_out=8`.
  - Ninth word 0xAA → `status_out=1`.
  - 3 further bits → 3 `overflow_out` pulses.
  - One `dequeue_in` → `status_out=0`, `len_out` stays 8, head becomes 0x02, tail is 0xAA.
- **Simultaneous push/pop at full:** last bit completes on the same edge as `dequeue_in` → word accepted without HOLD, `len_out` stays 8, no overflow.
- **Reset mid-word:** 3 bits, then `reset` pulse, then 8 bits forming 0xC3 → `data_out=0xC3`, `len_out=1`, no residue from the first 3 bits.
- **Wrap-around:** push/pop interleaved over 20 words 0x00..0x13 → words emerge in order, `len_out` never exceeds 8, `dequeue_in` on empty ignored.

Source files
------------

// File: rtl/serial_queue_bridge.sv
// Serial-to-parallel bridge: assembles WIDTH-bit words from a bit stream and
// queues them in a DEPTH-entry show-ahead FIFO, holding one word under backpressure.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_COLLECT | shifting bits in; completed word goes straight to the FIFO
// S_HOLD    | completed word parked in pending, incoming bits dropped
module serial_queue_bridge #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write_in,
  input  logic                       data_in,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       empty_out,
  output logic                       full_out,
  output logic                       status_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q;
  logic [WIDTH-1:0]  shift_q, shift_next;
  logic [WIDTH-1:0]  pending_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]     len_q;
  logic              overflow_q;

  logic              last_bit, word_done, pop, can_push, push;
  logic              latch_pending;
  logic [WIDTH-1:0]  push_data;

  assign last_bit  = (bit_cnt_q == CW'(WIDTH - 1));
  assign word_done = (state_q == S_COLLECT) && write_in && last_bit;
  assign pop       = dequeue_in && (len_q != '0);
  // A simultaneous pop frees a slot even when the FIFO is full
  assign can_push  = (len_q < LW'(DEPTH)) || pop;

  always_comb begin
    shift_next = shift_q;
    if (MSB_FIRST) shift_next = {shift_q[WIDTH-2:0], data_in};
    else           shift_next = {data_in, shift_q[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_COLLECT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (word_done && !can_push) state_d = S_HOLD;
      S_HOLD:    if (can_push)               state_d = S_COLLECT;
      default:                               state_d = S_COLLECT;
    endcase
  end

  // Output / datapath control
  always_comb begin
    push          = 1'b0;
    push_data     = shift_next;
    latch_pending = 1'b0;
    status_out    = 1'b0;
    case (state_q)
      S_COLLECT: begin
        push          = word_done && can_push;
        latch_pending = word_done && !can_push;
      end
      S_HOLD: begin
        status_out = 1'b1;
        push       = can_push;
        push_data  = pending_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= (state_q == S_HOLD) && write_in;
      if ((state_q == S_COLLECT) && write_in) begin
        shift_q   <= shift_next;
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CW'(1);
      end
      if (latch_pending) pending_q <= shift_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      len_q <= len_q + LW'(1);
      else if (pop && !push) len_q <= len_q - LW'(1);
    end
  end

  // Storage needs no reset; only entries below len are ever observed
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign len_out      = len_q;
  assign empty_out    = (len_q == '0);
  assign full_out     = (len_q == LW'(DEPTH));
  assign data_out     = empty_out ? '0 : mem[rd_ptr_q];
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_serial_queue_bridge.sv
// Bench for serial_queue_bridge: an MSB-first and an LSB-first instance share
// stimulus and are checked against a queue-based reference model plus fixed vectors.
module tb_serial_queue_bridge;

  localparam int W = 8;
  localparam int D = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic write_in = 1'b0, data_in = 1'b0, dequeue_in = 1'b0;

  logic [W-1:0] data_m, data_l;
  logic [3:0]   len_m, len_l;
  logic         empty_m, empty_l, full_m, full_l, status_m, status_l, ovf_m, ovf_l;

  int checks = 0;
  int errors = 0;

  serial_queue_bridge #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .write_in(write_in), .data_in(data_in),
    .dequeue_in(dequeue_in), .data_out(data_m), .len_out(len_m),
    .empty_out(empty_m), .full_out(full_m), .status_out(status_m),
    .overflow_out(ovf_m));

  serial_queue_bridge #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .write_in(write_in), .data_in(data_in),
    .dequeue_in(dequeue_in), .data_out(data_l), .len_out(len_l),
    .empty_out(empty_l), .full_out(full_l), .status_out(status_l),
    .overflow_out(ovf_l));

  always #5 clock = ~clock;

  // Reference model, index 0 = MSB-first, 1 = LSB-first
  int q0[$], q1[$];
  int bits0[$], bits1[$];
  bit hold[2];
  int pending[2];
  bit ovf_exp[2];

  function automatic int assemble(input int b[$], input bit msb);
    int v = 0;
    for (int i = 0; i < W; i++)
      v += b[i] * (msb ? (1 << (W - 1 - i)) : (1 << i));
    return v;
  endfunction

  task automatic model_edge_one(inout int q[$], inout int bits[$], input int k,
                                input bit w, input bit d, input bit deq);
    int  n = q.size();
    bit  pop_ok = deq && (n > 0);
    bit  space = (n < D) || pop_ok;
    ovf_exp[k] = hold[k] && w;
    if (pop_ok) void'(q.pop_front());
    if (hold[k]) begin
      if (space) begin
        q.push_back(pending[k]);
        hold[k] = 1'b0;
      end
    end else if (w) begin
      bits.push_back(int'(d));
      if (bits.size() == W) begin
        int word = assemble(bits, (k == 0));
        bits.delete();
        if (space) q.push_back(word);
        else begin
          hold[k]    = 1'b1;
          pending[k] = word;
        end
      end
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); bits0.delete(); bits1.delete();
    hold[0] = 0; hold[1] = 0; ovf_exp[0] = 0; ovf_exp[1] = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m.data",   int'(data_m),   q0.size() ? q0[0] : 0);
    chk("m.len",    int'(len_m),    q0.size());
    chk("m.empty",  int'(empty_m),  int'(q0.size() == 0));
    chk("m.full",   int'(full_m),   int'(q0.size() == D));
    chk("m.status", int'(status_m), int'(hold[0]));
    chk("m.ovf",    int'(ovf_m),    int'(ovf_exp[0]));
    chk("l.data",   int'(data_l),   q1.size() ? q1[0] : 0);
    chk("l.len",    int'(len_l),    q1.size());
    chk("l.empty",  int'(empty_l),  int'(q1.size() == 0));
    chk("l.full",   int'(full_l),   int'(q1.size() == D));
    chk("l.status", int'(status_l), int'(hold[1]));
    chk("l.ovf",    int'(ovf_l),    int'(ovf_exp[1]));
  endtask

  task automatic step(input bit w, input bit d, input bit deq);
    write_in = w; data_in = d; dequeue_in = deq;
    @(posedge clock);
    model_edge_one(q0, bits0, 0, w, d, deq);
    model_edge_one(q1, bits1, 1, w, d, deq);
    #1;
    compare_model();
    write_in = 0; data_in = 0; dequeue_in = 0;
  endtask

  task automatic send_word(input logic [7:0] v);
    for (int i = W - 1; i >= 0; i--) step(1'b1, v[i], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
    #1;
    compare_model();
  endtask

  typedef struct packed {
    logic       w, d, deq;
    logic [3:0] len;
    logic [7:0] dm, dl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int expect_next;
    logic [7:0] bpat;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 4'd1, 8'h52, 8'h4A};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00};

    model_reset();
    #12;
    compare_model();
    chk("reset.empty", int'(empty_m), 1);
    reset = 1'b0;
    @(negedge clock);

    // Bits 0,1,0,1,0,0,1,0 then a pop
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].deq);
      chk("vec.len_m",  int'(len_m),  int'(tbl[i].len));
      chk("vec.data_m", int'(data_m), int'(tbl[i].dm));
      chk("vec.data_l", int'(data_l), int'(tbl[i].dl));
    end

    // LSB-first: 0,1,0,0,1,0,1,0 -> 0x52
    bpat = 8'b0100_1010;
    for (int i = W - 1; i >= 0; i--) step(1'b1, bpat[i], 1'b0);
    chk("lsb.data", int'(data_l), 8'h52);
    step(1'b0, 1'b0, 1'b1);

    // Fill to full, then a ninth word into HOLD
    for (int v = 1; v <= 8; v++) send_word(8'(v));
    chk("fill.full", int'(full_m), 1);
    chk("fill.len",  int'(len_m), 8);
    send_word(8'hAA);
    chk("hold.status", int'(status_m), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("hold.ovf", int'(ovf_m), 1);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("hold.ovf_clear", int'(ovf_m), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("release.status", int'(status_m), 0);
    chk("release.len",    int'(len_m), 8);
    chk("release.head",   int'(data_m), 8'h02);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
    chk("release.tail", int'(data_m), 8'hAA);
    step(1'b0, 1'b0, 1'b1);

    // Completing bit coincides with a pop at full
    for (int v = 1; v <= 8; v++) send_word(8'(v + 16));
    bpat = 8'h5C;
    for (int i = W - 1; i >= 1; i--) step(1'b1, bpat[i], 1'b0);
    step(1'b1, bpat[0], 1'b1);
    chk("pushpop.status", int'(status_m), 0);
    chk("pushpop.len",    int'(len_m), 8);
    chk("pushpop.ovf",    int'(ovf_m), 0);
    chk("pushpop.head",   int'(data_m), 8'h12);

    // Reset mid-word, then 0xC3
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(8'hC3);
    chk("rstmid.data", int'(data_m), 8'hC3);
    chk("rstmid.len",  int'(len_m), 1);
    step(1'b0, 1'b0, 1'b1);

    // Interleaved push/pop over 20 words, then pop on empty
    expect_next = 0;
    for (int k = 0; k < 20; k++) begin
      send_word(8'(k));
      if (k >= 3) begin
        chk("wrap.order", int'(data_m), expect_next);
        expect_next++;
        step(1'b0, 1'b0, 1'b1);
      end
    end
    while (expect_next < 20) begin
      chk("wrap.order", int'(data_m), expect_next);
      expect_next++;
      step(1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("wrap.empty_pop", int'(len_m), 0);

    // Randomized phases: low pop rate forces HOLD, higher rate drains
    for (int ph = 0; ph < 4; ph++) begin
      int pop_pct = (ph % 2 == 0) ? 8 : 55;
      for (int c = 0; c < 600; c++) begin
        step(($urandom_range(99) < 70), 1'($urandom), ($urandom_range(99) < pop_pct));
      end
      if (ph == 2) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
